// File: rtl/mult_result_accum.sv
// Frame-aligned sampler and batch accumulator for the 8x8 frame-based multiplier.
// Optional MULT_ACCUM_SKID_EN turns the single result slot into a 2-entry in-order FIFO.
module mult_result_accum #(
  parameter int FRAME = 10,
  parameter int BATCH = 4,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_product,
  output logic [ACC_W-1:0] o_sum_data,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_dropped,
  output logic             o_overflow
);

  localparam int PH_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;

  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic             r_dropped;

  logic             w_sample;
  logic             w_complete;
  logic             w_xfer;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (r_phase == PH_W'(FRAME - 1)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  always_comb begin
    w_sample   = (r_phase == PH_W'(FRAME - 1));
    w_complete = w_sample && (r_count == CNT_W'(BATCH - 1));
    w_xfer     = o_sum_valid && i_sum_ready;
    w_sum_ext  = {1'b0, r_acc} + (ACC_W + 1)'(i_product);
    w_sum      = w_sum_ext[ACC_W-1:0];
    w_carry    = w_sum_ext[ACC_W];
  end

  // The final sample of a batch restarts the accumulator from zero rather than keeping the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_sample) begin
      if (w_carry) begin
        r_overflow <= 1'b1;
      end
      if (w_complete) begin
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_acc   <= w_sum;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef MULT_ACCUM_SKID_EN
  logic [ACC_W-1:0] r_head;
  logic [ACC_W-1:0] r_tail;
  logic [1:0]       r_occ;

  // Head is the oldest result; a pop that empties the FIFO leaves the head value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_occ     <= 2'd0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case ({w_complete, w_xfer})
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_tail <= w_sum;
          end else begin
            r_head <= w_sum;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= w_sum;
            r_occ  <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_tail <= w_sum;
            r_occ  <= 2'd2;
          end else begin
            r_dropped <= 1'b1;
          end
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
          end
          r_occ <= r_occ - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_sum_data  = r_head;
  assign o_sum_valid = (r_occ != 2'd0);
`else
  logic [ACC_W-1:0] r_sum_data;
  logic             r_sum_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_data  <= '0;
      r_sum_valid <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      if (w_complete) begin
        if (!r_sum_valid || w_xfer) begin
          r_sum_data  <= w_sum;
          r_sum_valid <= 1'b1;
        end else begin
          r_dropped <= 1'b1;
        end
      end else if (w_xfer) begin
        r_sum_valid <= 1'b0;
      end
    end
  end

  assign o_sum_data  = r_sum_data;
  assign o_sum_valid = r_sum_valid;
`endif

  assign o_dropped  = r_dropped;
  assign o_overflow = r_overflow;

endmodule
